// File: rtl/s2c_call_arb.sv
// Round-robin arbiter sharing one SV-to-C call channel among N requesters.
// One call is outstanding at a time; the response goes back to the granted requester only.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | search requests from last+1 upward, accept one, latch id/fn
//  ISSUE  | call_valid held with latched id/fn until the bridge accepts
//  WAIT   | wait for done_valid or the timeout terminal count
//  RESP   | one-cycle rsp_valid to the granted requester, update last
module s2c_call_arb #(
    parameter int N       = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [8*N-1:0]  req_id,
    input  logic [8*N-1:0]  req_fn,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    rsp_valid,
    output logic [31:0]     rsp_ret,
    output logic [DW-1:0]   rsp_data,
    output logic            call_valid,
    output logic [7:0]      call_id,
    output logic [7:0]      call_fn,
    input  logic            call_ready,
    input  logic            done_valid,
    input  logic [31:0]     done_ret,
    input  logic [DW-1:0]   done_data,
    output logic            err_stray
);

    localparam int LW    = (N > 1) ? $clog2(N) : 1;
    localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(TLAST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   last;
    logic [LW-1:0]   gnt;
    logic [LW-1:0]   gnt_idx;
    logic [LW-1:0]   cand;
    logic            gnt_found;
    logic            accept;
    logic            timeout_hit;
    logic [N-1:0]    gnt_oh;
    logic [CW-1:0]   cnt;

    // Rotating priority: the first set request above the last winner.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = LW'((int'(last) + k) % N);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign accept      = (state == S_IDLE) && gnt_found && !rst;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        gnt_oh      = '0;
        gnt_oh[gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)                    state_nxt = S_ISSUE;
            S_ISSUE: if (call_ready)                state_nxt = S_WAIT;
            S_WAIT:  if (done_valid || timeout_hit) state_nxt = S_RESP;
            S_RESP:                                 state_nxt = S_IDLE;
            default:                                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= LW'(N - 1);
            gnt        <= '0;
            cnt        <= '0;
            call_valid <= 1'b0;
            call_id    <= '0;
            call_fn    <= '0;
            rsp_valid  <= '0;
            rsp_ret    <= '0;
            rsp_data   <= '0;
            err_stray  <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (done_valid && (state != S_WAIT)) begin
                err_stray <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        gnt        <= gnt_idx;
                        call_id    <= req_id[8*gnt_idx +: 8];
                        call_fn    <= req_fn[8*gnt_idx +: 8];
                        call_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (call_ready) begin
                        call_valid <= 1'b0;
                        cnt        <= '0;
                    end
                end
                S_WAIT: begin
                    // A completion arriving on the terminal-count cycle takes priority.
                    if (done_valid) begin
                        rsp_ret   <= done_ret;
                        rsp_data  <= done_data;
                        rsp_valid <= gnt_oh;
                    end else if (timeout_hit) begin
                        rsp_ret   <= 32'd2;
                        rsp_data  <= '0;
                        rsp_valid <= gnt_oh;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    last <= gnt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_s2c_call_arb.sv
// Directed bench for s2c_call_arb: table of single transactions plus hand sequences
// for ISSUE stall, timeout, timeout/done collision, stray completion and reset in WAIT.
module tb_s2c_call_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_id;
    logic [8*N-1:0]  req_fn;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_ret;
    logic [DW-1:0]   rsp_data;
    logic            call_valid;
    logic [7:0]      call_id;
    logic [7:0]      call_fn;
    logic            call_ready;
    logic            done_valid;
    logic [31:0]     done_ret;
    logic [DW-1:0]   done_data;
    logic            err_stray;

    s2c_call_arb #(.N(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_id     (req_id),
        .req_fn     (req_fn),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ret    (rsp_ret),
        .rsp_data   (rsp_data),
        .call_valid (call_valid),
        .call_id    (call_id),
        .call_fn    (call_fn),
        .call_ready (call_ready),
        .done_valid (done_valid),
        .done_ret   (done_ret),
        .done_data  (done_data),
        .err_stray  (err_stray)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] ids;
        logic [31:0] fns;
        int          dly;
        logic [31:0] ret;
        logic [31:0] data;
        logic [3:0]  exp_rdy;
        logic [7:0]  exp_id;
        logic [7:0]  exp_fn;
    } vec_t;

    localparam logic [31:0] IDS = 32'h1312_1110;
    localparam logic [31:0] FNS = 32'h2322_2120;

    vec_t vecs[14];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        req_valid = v.mask;
        req_id    = v.ids;
        req_fn    = v.fns;
        #1;
        chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(v.exp_rdy));
        tick;
        chk($sformatf("v%0d call_valid", i), 32'(call_valid), 32'd1);
        chk($sformatf("v%0d call_id", i), 32'(call_id), 32'(v.exp_id));
        chk($sformatf("v%0d call_fn", i), 32'(call_fn), 32'(v.exp_fn));
        chk($sformatf("v%0d busy req_ready", i), 32'(req_ready), 32'd0);
        call_ready = 1'b1;
        tick;
        call_ready = 1'b0;
        repeat (v.dly) tick;
        done_valid = 1'b1;
        done_ret   = v.ret;
        done_data  = v.data;
        tick;
        done_valid = 1'b0;
        chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(v.exp_rdy));
        chk($sformatf("v%0d rsp_ret", i), rsp_ret, v.ret);
        chk($sformatf("v%0d rsp_data", i), rsp_data, v.data);
        tick;
        chk($sformatf("v%0d rsp_valid drop", i), 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'hF, IDS, FNS, 0, 32'd0, 32'h0000_00A0, 4'b0001, 8'h10, 8'h20};
        vecs[1]  = '{4'hF, IDS, FNS, 1, 32'd1, 32'h0000_00A1, 4'b0010, 8'h11, 8'h21};
        vecs[2]  = '{4'hF, IDS, FNS, 0, 32'd0, 32'h0000_00A2, 4'b0100, 8'h12, 8'h22};
        vecs[3]  = '{4'hF, IDS, FNS, 3, 32'd5, 32'h0000_00A3, 4'b1000, 8'h13, 8'h23};
        vecs[4]  = '{4'hF, IDS, FNS, 2, 32'd0, 32'h0000_00B0, 4'b0001, 8'h10, 8'h20};
        vecs[5]  = '{4'hF, IDS, FNS, 0, 32'hFFFF_FFFF, 32'h0000_00B1, 4'b0010, 8'h11, 8'h21};
        vecs[6]  = '{4'hF, IDS, FNS, 1, 32'd1, 32'h0000_00B2, 4'b0100, 8'h12, 8'h22};
        vecs[7]  = '{4'hF, IDS, FNS, 0, 32'd0, 32'h0000_00B3, 4'b1000, 8'h13, 8'h23};
        vecs[8]  = '{4'b0010, 32'h1312_0510, 32'h2322_0020, 0, 32'd0, 32'h0000_0001, 4'b0010, 8'h05, 8'h00};
        vecs[9]  = '{4'b1010, IDS, FNS, 2, 32'hDEAD_0003, 32'h0000_00C9, 4'b1000, 8'h13, 8'h23};
        vecs[10] = '{4'b1010, IDS, FNS, 0, 32'd1, 32'h0000_00CA, 4'b0010, 8'h11, 8'h21};
        vecs[11] = '{4'b0101, IDS, FNS, 1, 32'd0, 32'h0000_00CB, 4'b0100, 8'h12, 8'h22};
        vecs[12] = '{4'b0001, IDS, FNS, 0, 32'd0, 32'h0000_00CC, 4'b0001, 8'h10, 8'h20};
        vecs[13] = '{4'b1001, IDS, FNS, 0, 32'd4, 32'h0000_00CD, 4'b1000, 8'h13, 8'h23};

        rst        = 1'b1;
        req_valid  = '0;
        req_id     = '0;
        req_fn     = '0;
        call_ready = 1'b0;
        done_valid = 1'b0;
        done_ret   = '0;
        done_data  = '0;
        repeat (2) tick;

        req_valid = 4'hF;
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset call_valid", 32'(call_valid), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_ret", rsp_ret, 32'd0);
        chk("reset call_id", 32'(call_id), 32'd0);
        chk("reset err_stray", 32'(err_stray), 32'd0);
        req_valid = '0;
        rst       = 1'b0;
        tick;

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end
        req_valid = '0;
        chk("no stray after table", 32'(err_stray), 32'd0);

        // ISSUE stall for 5 cycles with request inputs scrambled, then timeout.
        req_valid = 4'b0100;
        req_id    = IDS;
        req_fn    = FNS;
        #1;
        chk("stall req_ready", 32'(req_ready), 32'b0100);
        tick;
        req_valid = '0;
        req_id    = '0;
        req_fn    = '1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d call_valid", c), 32'(call_valid), 32'd1);
            chk($sformatf("stall%0d call_id", c), 32'(call_id), 32'h12);
            chk($sformatf("stall%0d call_fn", c), 32'(call_fn), 32'h22);
            tick;
        end
        chk("stall end call_valid", 32'(call_valid), 32'd1);
        call_ready = 1'b1;
        tick;
        call_ready = 1'b0;
        begin
            int k;
            k = 1;
            while (rsp_valid == '0 && k < 40) begin
                tick;
                k++;
            end
            chk("timeout latency", 32'(k), 32'd17);
        end
        chk("timeout rsp_valid", 32'(rsp_valid), 32'b0100);
        chk("timeout rsp_ret", rsp_ret, 32'd2);
        chk("timeout rsp_data", rsp_data, 32'd0);
        tick;

        // done_valid on the terminal-count cycle wins over the timeout code.
        req_valid = 4'b1000;
        req_id    = IDS;
        req_fn    = FNS;
        #1;
        chk("coll req_ready", 32'(req_ready), 32'b1000);
        tick;
        req_valid  = '0;
        call_ready = 1'b1;
        tick;
        call_ready = 1'b0;
        repeat (TO - 1) tick;
        done_valid = 1'b1;
        done_ret   = 32'd1;
        done_data  = 32'h0000_0055;
        tick;
        done_valid = 1'b0;
        chk("coll rsp_valid", 32'(rsp_valid), 32'b1000);
        chk("coll rsp_ret", rsp_ret, 32'd1);
        chk("coll rsp_data", rsp_data, 32'h55);
        chk("coll err_stray", 32'(err_stray), 32'd0);
        tick;

        // Stray completion in IDLE.
        done_valid = 1'b1;
        done_ret   = 32'd7;
        tick;
        done_valid = 1'b0;
        chk("stray err_stray", 32'(err_stray), 32'd1);
        chk("stray rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) tick;
        chk("stray sticky", 32'(err_stray), 32'd1);
        chk("stray rsp_ret held", rsp_ret, 32'd1);

        // Reset in WAIT aborts the call and restores requester 0 priority.
        req_valid = 4'b0010;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'b0010);
        tick;
        call_ready = 1'b1;
        tick;
        call_ready = 1'b0;
        rst        = 1'b1;
        tick;
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst call_valid", 32'(call_valid), 32'd0);
        chk("rst call_id", 32'(call_id), 32'd0);
        chk("rst call_fn", 32'(call_fn), 32'd0);
        chk("rst rsp_ret", rsp_ret, 32'd0);
        chk("rst rsp_data", rsp_data, 32'd0);
        chk("rst err_stray", 32'(err_stray), 32'd0);
        chk("rst held req_ready", 32'(req_ready), 32'd0);
        rst       = 1'b0;
        req_valid = 4'b0101;
        #1;
        chk("post-rst req_ready", 32'(req_ready), 32'b0001);
        tick;
        req_valid = '0;
        chk("post-rst call_id", 32'(call_id), 32'h10);
        call_ready = 1'b1;
        tick;
        call_ready = 1'b0;
        done_valid = 1'b1;
        done_ret   = 32'd0;
        done_data  = 32'h0000_0077;
        tick;
        done_valid = 1'b0;
        chk("post-rst rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("post-rst rsp_data", rsp_data, 32'h77);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
